dot4x_phase_gen: RTL

Derives the VIC-II timing phases from the muxed dot4x clock produced by the clock generator. It waits for the PLL lock to be synchronised and stable, then runs a 32-tick phase counter, one full PHI cycle of 8 pixels × 4 ticks. From that counter it emits registered dot and PHI strobes. Every downstream timing block (raster counters, sprite/bus sequencers, DVI pixel feed) keys off these strobes instead of building its own divider.

---
 rtl/dot4x_phase_gen_pkg.sv | 18 +
 rtl/dot4x_phase_gen_sync2.sv | 21 ++
 rtl/dot4x_phase_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dot4x_phase_gen_pkg.sv
// Shared definitions for the dot4x phase generator: FSM state encoding and
// phase constants for the 32-tick PHI cycle (8 pixels x 4 dot4x ticks).
package dot4x_phase_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [4:0] PHASE_LAST     = 5'd31;
  localparam logic [4:0] PHI_RISE_PHASE = 5'd16;

  function automatic logic [4:0] phase_inc(input logic [4:0] p);
    return (p == PHASE_LAST) ? 5'd0 : p + 5'd1;
  endfunction

endpackage

// File: rtl/dot4x_phase_gen_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
module dot4x_phase_gen_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dot4x_phase_gen.sv
// VIC-II phase generator: waits for a settled PLL lock, then runs a 32-tick
// phase counter with registered dot/PHI strobes. Optional macro: CHIP_RESYNC_EN.
module dot4x_phase_gen
  import dot4x_phase_gen_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic       locked,
  input  logic [1:0] chip,
  output logic       run,
  output logic [4:0] phase,
  output logic       clk_phi,
  output logic       dot_rising,
  output logic       phi_rising,
  output logic       phi_falling,
  output logic [1:0] chip_latched
);

  localparam int unsigned     CNT_W    = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [4:0]       phase_next;
  logic [1:0]       chip_q;
  logic             locked_s;
  logic             latch_chip;
  logic             run_next;

  dot4x_phase_gen_sync2 u_lock_sync (
    .clk   (clk_dot4x),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

`ifdef CHIP_RESYNC_EN
  logic [1:0] chip_prev;

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) chip_prev <= '0;
    else        chip_prev <= chip_q;
  end
`else
  // Chip is strapped: only the first entry to RUN after reset captures it.
  logic seen_run;

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n)                          seen_run <= 1'b0;
    else if (state_next == RUN)          seen_run <= 1'b1;
  end
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    phase_next = '0;
    latch_chip = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (locked_s) state_next = SETTLE;
      end
      SETTLE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
`ifdef CHIP_RESYNC_EN
        else if (chip_q != chip_prev) begin
          cnt_next = '0;
        end
`endif
        else if (cnt == CNT_LAST) begin
          state_next = RUN;
`ifdef CHIP_RESYNC_EN
          latch_chip = 1'b1;
`else
          latch_chip = !seen_run;
`endif
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
`ifdef CHIP_RESYNC_EN
        else if (chip_q != chip_latched) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
`endif
        else begin
          phase_next = phase_inc(phase);
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
    run_next = (state_next == RUN);
  end

  // Strobes decode the next phase so they line up with the cycle showing it.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      chip_q       <= '0;
      phase        <= '0;
      run          <= 1'b0;
      clk_phi      <= 1'b0;
      dot_rising   <= 1'b0;
      phi_rising   <= 1'b0;
      phi_falling  <= 1'b0;
      chip_latched <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      chip_q      <= chip;
      phase       <= phase_next;
      run         <= run_next;
      clk_phi     <= run_next & phase_next[4];
      dot_rising  <= run_next & (phase_next[1:0] == 2'd0);
      phi_rising  <= run_next & (phase_next == PHI_RISE_PHASE);
      phi_falling <= run_next & (phase_next == 5'd0);
      if (latch_chip) chip_latched <= chip_q;
    end
  end

endmodule
